// File: rtl/mem_seq_pkg.sv
// Shared types for the memory command sequencer: command opcodes, FSM states
// and a small opcode helper.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE1 = 2'b00,
    OP_READ1  = 2'b01,
    OP_FILL   = 2'b10,
    OP_SCAN   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  function automatic logic isWriteOp(input op_e op);
    return (op == OP_WRITE1) || (op == OP_FILL);
  endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// Command and RAM-side bus of the memory sequencer; the sequencer is the slave,
// whoever issues commands and models the RAM is the master.
interface mem_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  import mem_seq_pkg::*;

  logic              start;
  op_e               op;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport slave (
    input  start, op, addr_in, data_in, ram_q,
    output ram_address, ram_data, ram_wren, busy, done, rd_data, rd_valid
  );

  modport master (
    output start, op, addr_in, data_in, ram_q,
    input  ram_address, ram_data, ram_wren, busy, done, rd_data, rd_valid
  );

endinterface

// File: rtl/mem_sequencer_detecta_borda.sv
// Rising-edge detector for the start request: one history flop and an AND-NOT.
module detecta_borda (
  input  logic clock,
  input  logic resetn,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sig_q <= 1'b0;
    else         sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/mem_sequencer.sv
// Memory command sequencer: runs single or burst writes/reads against a
// synchronous RAM, one word per step, never wrapping past the top address.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input logic             clock,
  input logic             resetn,
  mem_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
  localparam logic [1:0]        LAST_WAIT = 2'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        waitCnt_q, waitCnt_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              startRise;

  detecta_borda u_edge (
    .clock  (clock),
    .resetn (resetn),
    .sig_i  (bus.start),
    .rise_o (startRise)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_WRITE1;
      addr_q    <= '0;
      data_q    <= '0;
      waitCnt_q <= '0;
      rdData_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      waitCnt_q <= waitCnt_d;
      rdData_q  <= rdData_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    waitCnt_d = waitCnt_q;
    rdData_d  = rdData_q;
    case (state_q)
      ST_IDLE: begin
        if (startRise) begin
          op_d      = bus.op;
          addr_d    = bus.addr_in;
          data_d    = bus.data_in;
          waitCnt_d = '0;
          state_d   = isWriteOp(bus.op) ? ST_WRITE : ST_READ_WAIT;
        end
      end
      ST_WRITE: begin
        // FILL walks up to the top address and stops there; the seed advances with it
        if (op_q == OP_FILL && addr_q != TOP_ADDR) begin
          addr_d = addr_q + 1'b1;
          data_d = data_q + 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_READ_WAIT: begin
        if (waitCnt_q == LAST_WAIT) begin
          waitCnt_d = '0;
          state_d   = ST_CAPTURE;
        end else begin
          waitCnt_d = waitCnt_q + 2'd1;
        end
      end
      ST_CAPTURE: begin
        rdData_d = bus.ram_q;
        if (op_q == OP_SCAN && addr_q != TOP_ADDR) begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_READ_WAIT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.ram_address = addr_q;
  assign bus.ram_data    = data_q;
  assign bus.ram_wren    = (state_q == ST_WRITE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.rd_valid    = (state_q == ST_CAPTURE);
  // The fresh word is shown live during CAPTURE so it lines up with rd_valid;
  // the register keeps it visible afterwards.
  assign bus.rd_data     = (state_q == ST_CAPTURE) ? bus.ram_q : rdData_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: a latency-1 instance checked every cycle
// against a command-level model, plus a latency-2 instance checked directly.
module tb_mem_sequencer;
  import mem_seq_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int LAT_A = 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic clock;
  logic resetn;

  mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) busA ();
  mem_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) busB ();

  mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT_A)) dutA (
    .clock  (clock),
    .resetn (resetn),
    .bus    (busA)
  );

  mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dutB (
    .clock  (clock),
    .resetn (resetn),
    .bus    (busB)
  );

  int compared   = 0;
  int mismatched = 0;

  // Command-level model state: expected writes/reads in order, cycle bookkeeping
  wr_t        expWrites [$];
  wr_t        obsWrites [$];
  logic [7:0] expReads  [$];
  logic [7:0] obsReads  [$];
  logic [7:0] shadow    [32];
  int         cycle      = 0;
  int         cmdBase    = 0;
  int         doneAt     = -1;
  bit         cmdActive  = 1'b0;
  int         lastDoneAt = -1;

  // RAM models: A reads with one cycle of latency, B with two and fixed contents
  logic [7:0] ramA [32];
  logic [7:0] qA, s1B, qB;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (busA.ram_wren) ramA[busA.ram_address] <= busA.ram_data;
    qA  <= ramA[busA.ram_address];
    s1B <= ({3'b000, busB.ram_address} * 8'd3) + 8'd1;
    qB  <= s1B;
  end

  assign busA.ram_q = qA;
  assign busB.ram_q = qB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every falling edge: writes and reads must match the model queues in order,
  // busy/done must follow the command's expected length.
  initial begin : compareProc
    int         mc;
    logic       expBusy, expDone;
    wr_t        e;
    logic [7:0] r;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        expWrites.delete();
        expReads.delete();
      end else begin
        mc = cycle - cmdBase;
        if (busA.ram_wren) begin
          obsWrites.push_back('{a: busA.ram_address, d: busA.ram_data});
          checkOutput("write_expected", 32'(expWrites.size() != 0), 32'(1));
          if (expWrites.size() != 0) begin
            e = expWrites.pop_front();
            checkOutput("write_addr", 32'(busA.ram_address), 32'(e.a));
            checkOutput("write_data", 32'(busA.ram_data), 32'(e.d));
            shadow[e.a] = e.d;
          end
        end
        if (busA.rd_valid) begin
          obsReads.push_back(busA.rd_data);
          checkOutput("read_expected", 32'(expReads.size() != 0), 32'(1));
          if (expReads.size() != 0) begin
            r = expReads.pop_front();
            checkOutput("rd_data", 32'(busA.rd_data), 32'(r));
          end
        end
        expBusy = cmdActive && (mc >= 1) && (mc <= doneAt);
        expDone = cmdActive && (mc >= 1) && (mc == doneAt);
        checkOutput("busy", 32'(busA.busy), 32'(expBusy));
        checkOutput("done", 32'(busA.done), 32'(expDone));
        if (busA.done) lastDoneAt = mc;
      end
      cycle++;
    end
  end

  // Issue one command on instance A; cycle 0 is the cycle start first reads high.
  task automatic applyStimulus(input op_e op, input int addr, input logic [7:0] data, input bit toggle);
    int n;
    int doneCycle;
    n = 32 - addr;
    doneCycle = 0;
    @(posedge clock); #1;
    case (op)
      OP_WRITE1: begin
        doneCycle = 2;
        expWrites.push_back('{a: 5'(addr), d: data});
      end
      OP_FILL: begin
        doneCycle = n + 1;
        for (int i = 0; i < n; i++) expWrites.push_back('{a: 5'(addr + i), d: 8'(data + 8'(i))});
      end
      OP_READ1: begin
        doneCycle = LAT_A + 2;
        expReads.push_back(shadow[5'(addr)]);
      end
      default: begin
        doneCycle = n * (LAT_A + 1) + 1;
        for (int i = 0; i < n; i++) expReads.push_back(shadow[5'(addr + i)]);
      end
    endcase
    busA.op      = op;
    busA.addr_in = 5'(addr);
    busA.data_in = data;
    busA.start   = 1'b1;
    cmdBase      = cycle;
    doneAt       = doneCycle;
    cmdActive    = 1'b1;
    for (int c = 1; c <= doneCycle + 3; c++) begin
      @(posedge clock); #1;
      busA.op      = op_e'(~op);
      busA.addr_in = ~5'(addr);
      busA.data_in = ~data;
      if (!toggle)                busA.start = 1'b0;
      else if (c < doneCycle - 3) busA.start = c[1];
      else                        busA.start = 1'b1;
    end
    busA.start = 1'b0;
    @(posedge clock); #1;
    checkOutput("pending_writes", 32'(expWrites.size()), 32'(0));
    checkOutput("pending_reads", 32'(expReads.size()), 32'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int         wb;
    int         rb;
    logic [7:0] fillData [4];
    fillData = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    busA.start = 1'b0; busA.op = OP_WRITE1; busA.addr_in = '0; busA.data_in = '0;
    busB.start = 1'b0; busB.op = OP_WRITE1; busB.addr_in = '0; busB.data_in = '0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst_wren",     32'(busA.ram_wren),    32'(0));
    checkOutput("rst_busy",     32'(busA.busy),        32'(0));
    checkOutput("rst_done",     32'(busA.done),        32'(0));
    checkOutput("rst_rd_valid", 32'(busA.rd_valid),    32'(0));
    checkOutput("rst_address",  32'(busA.ram_address), 32'(0));
    checkOutput("rst_ram_data", 32'(busA.ram_data),    32'(0));
    checkOutput("rst_rd_data",  32'(busA.rd_data),     32'(0));
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    $display("[TB] WRITE1 addr 5 data 0xA7");
    wb = obsWrites.size();
    applyStimulus(OP_WRITE1, 5, 8'hA7, 1'b0);
    checkOutput("w1_count", 32'(obsWrites.size() - wb), 32'(1));
    if (obsWrites.size() > wb) begin
      checkOutput("w1_addr", 32'(obsWrites[wb].a), 32'(5));
      checkOutput("w1_data", 32'(obsWrites[wb].d), 32'h0000_00A7);
    end
    checkOutput("w1_done_cycle", 32'(lastDoneAt), 32'(2));

    $display("[TB] FILL addr 28 seed 0xFE");
    wb = obsWrites.size();
    applyStimulus(OP_FILL, 28, 8'hFE, 1'b0);
    checkOutput("fill28_count", 32'(obsWrites.size() - wb), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (obsWrites.size() > wb + i) begin
        checkOutput("fill28_addr", 32'(obsWrites[wb + i].a), 32'(28 + i));
        checkOutput("fill28_data", 32'(obsWrites[wb + i].d), 32'(fillData[i]));
      end
    end
    checkOutput("fill28_done_cycle", 32'(lastDoneAt), 32'(5));

    $display("[TB] SCAN addr 30 over 0x11/0x22");
    applyStimulus(OP_WRITE1, 30, 8'h11, 1'b0);
    applyStimulus(OP_WRITE1, 31, 8'h22, 1'b0);
    rb = obsReads.size();
    applyStimulus(OP_SCAN, 30, 8'h00, 1'b0);
    checkOutput("scan_count", 32'(obsReads.size() - rb), 32'(2));
    if (obsReads.size() >= rb + 2) begin
      checkOutput("scan_word0", 32'(obsReads[rb]),     32'h0000_0011);
      checkOutput("scan_word1", 32'(obsReads[rb + 1]), 32'h0000_0022);
    end
    checkOutput("scan_done_cycle", 32'(lastDoneAt), 32'(5));

    $display("[TB] READ1 addr 5");
    rb = obsReads.size();
    applyStimulus(OP_READ1, 5, 8'h00, 1'b0);
    checkOutput("r1_count", 32'(obsReads.size() - rb), 32'(1));
    if (obsReads.size() > rb) checkOutput("r1_word", 32'(obsReads[rb]), 32'h0000_00A7);
    checkOutput("r1_done_cycle", 32'(lastDoneAt), 32'(3));

    $display("[TB] FILL addr 0 seed 0x10 with start toggling");
    wb = obsWrites.size();
    applyStimulus(OP_FILL, 0, 8'h10, 1'b1);
    checkOutput("fill0_count", 32'(obsWrites.size() - wb), 32'(32));
    checkOutput("fill0_done_cycle", 32'(lastDoneAt), 32'(33));

    rb = obsReads.size();
    applyStimulus(OP_READ1, 5, 8'h00, 1'b0);
    if (obsReads.size() > rb) checkOutput("r1_after_fill", 32'(obsReads[rb]), 32'h0000_0015);
    else checkOutput("r1_after_fill_count", 32'(obsReads.size() - rb), 32'(1));

    $display("[TB] reset during third FILL write");
    wb = obsWrites.size();
    @(posedge clock); #1;
    for (int i = 0; i < 32; i++) expWrites.push_back('{a: 5'(i), d: 8'(8'h40 + 8'(i))});
    busA.op = OP_FILL; busA.addr_in = '0; busA.data_in = 8'h40; busA.start = 1'b1;
    cmdBase = cycle; doneAt = 33; cmdActive = 1'b1;
    @(posedge clock); #1 busA.start = 1'b0;
    @(posedge clock);
    @(posedge clock); #3;
    checkOutput("abort_pre_wren", 32'(busA.ram_wren),    32'(1));
    checkOutput("abort_pre_addr", 32'(busA.ram_address), 32'(2));
    resetn = 1'b0;
    cmdActive = 1'b0;
    #1;
    checkOutput("abort_wren", 32'(busA.ram_wren),    32'(0));
    checkOutput("abort_busy", 32'(busA.busy),        32'(0));
    checkOutput("abort_addr", 32'(busA.ram_address), 32'(0));
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("abort_write_count", 32'(obsWrites.size() - wb), 32'(2));
    checkOutput("abort_idle_busy",   32'(busA.busy),             32'(0));

    wb = obsWrites.size();
    applyStimulus(OP_WRITE1, 7, 8'h3C, 1'b0);
    checkOutput("post_reset_w1_count", 32'(obsWrites.size() - wb), 32'(1));

    $display("[TB] READ1 addr 31 with READ_LATENCY=2");
    @(posedge clock); #1;
    busB.op = OP_READ1; busB.addr_in = 5'd31; busB.data_in = '0; busB.start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checkOutput("lat2_rd_valid", 32'(busB.rd_valid), 32'(c == 3));
      checkOutput("lat2_done",     32'(busB.done),     32'(c == 4));
      if (c == 3) checkOutput("lat2_rd_data", 32'(busB.rd_data), 32'h0000_005E);
      @(posedge clock); #1;
      busB.start   = 1'b0;
      busB.addr_in = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
